// File: rtl/sbase_psw_debounce_one.sv
// Push-switch conditioner: synchronise, debounce, then emit press/release,
// long-press and auto-repeat single-cycle pulses for downstream TRG_ONE inputs.
module sbase_psw_debounce_one #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DB_CYCLES      = 500000,
  parameter int unsigned LONG_CYCLES    = 50000000,
  parameter int unsigned REPEAT_CYCLES  = 10000000,
  parameter int unsigned PSW_ACTIVE_LOW = 0
) (
  input  logic CLK,
  input  logic R_N,
  input  logic PSW,
  input  logic EN,
  output logic LEVEL,
  output logic TRG_ONE,
  output logic REL_ONE,
  output logic LONG_ONE,
  output logic REP_ONE
);

  localparam int unsigned DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int unsigned REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_CYCLES == 0) ? 32'd0 : REPEAT_CYCLES - 1);
  localparam logic              REP_EN    = (REPEAT_CYCLES != 0);
  localparam logic              INVERT    = (PSW_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] warm_q, warm_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
  state_e                 state_q, state_d;
  logic                   level_q, level_d;
  logic                   armed_q, armed_d;
  logic                   trg_one_q, trg_one_d;
  logic                   rel_one_q, rel_one_d;
  logic                   long_one_q, long_one_d;
  logic                   rep_one_q, rep_one_d;

  logic s;
  logic fire;
  logic rise;
  logic fall;

  assign s    = sync_q[SYNC_STAGES-1];
  assign fire = armed_q & EN;

  // Next-state: debounce window, press-state FSM, hold/repeat timers, pulses.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], PSW ^ INVERT};
    warm_d     = {warm_q[SYNC_STAGES-2:0], 1'b1};
    db_cnt_d   = db_cnt_q;
    level_d    = level_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    state_d    = state_q;
    armed_d    = armed_q;
    trg_one_d  = 1'b0;
    rel_one_d  = 1'b0;
    long_one_d = 1'b0;
    rep_one_d  = 1'b0;

    if (s == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = ~level_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end

    rise = level_d & ~level_q;
    fall = ~level_d & level_q;

    case (state_q)
      ST_RELEASED: begin
        if (rise) begin
          state_d    = ST_PRESSED;
          hold_cnt_d = '0;
          trg_one_d  = fire;
        end else if (!level_q && warm_q[SYNC_STAGES-1] && !s) begin
          // Arm only once the synchroniser holds real samples showing release.
          armed_d = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (fall) begin
          state_d    = ST_RELEASED;
          rel_one_d  = fire;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
          armed_d    = 1'b1;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_LONG_HELD;
          long_one_d = fire;
          hold_cnt_d = HOLD_MAX;
          rep_cnt_d  = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_LONG_HELD: begin
        if (fall) begin
          state_d    = ST_RELEASED;
          rel_one_d  = fire;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
          armed_d    = 1'b1;
        end else if (REP_EN) begin
          if (rep_cnt_q == REP_LAST) begin
            rep_one_d = fire;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_RELEASED;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      sync_q     <= '0;
      warm_q     <= '0;
      db_cnt_q   <= '0;
      level_q    <= 1'b0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      state_q    <= ST_RELEASED;
      armed_q    <= 1'b0;
      trg_one_q  <= 1'b0;
      rel_one_q  <= 1'b0;
      long_one_q <= 1'b0;
      rep_one_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      warm_q     <= warm_d;
      db_cnt_q   <= db_cnt_d;
      level_q    <= level_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      state_q    <= state_d;
      armed_q    <= armed_d;
      trg_one_q  <= trg_one_d;
      rel_one_q  <= rel_one_d;
      long_one_q <= long_one_d;
      rep_one_q  <= rep_one_d;
    end
  end

  assign LEVEL    = level_q;
  assign TRG_ONE  = trg_one_q;
  assign REL_ONE  = rel_one_q;
  assign LONG_ONE = long_one_q;
  assign REP_ONE  = rep_one_q;

endmodule

// File: tb/tb_sbase_psw_debounce_one.sv
// Bench for sbase_psw_debounce_one: edge-level behavioural model compared every
// cycle, plus hand-computed pulse timings for each directed scenario.
module tb_sbase_psw_debounce_one;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int LONG = 10;
  localparam int REP  = 3;

  logic CLK = 1'b0;
  logic R_N = 1'b1;
  logic PSW = 1'b0;
  logic EN  = 1'b1;
  logic LEVEL, TRG_ONE, REL_ONE, LONG_ONE, REP_ONE;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  sbase_psw_debounce_one #(
    .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .LONG_CYCLES(LONG),
    .REPEAT_CYCLES(REP), .PSW_ACTIVE_LOW(0)
  ) dut (
    .CLK(CLK), .R_N(R_N), .PSW(PSW), .EN(EN),
    .LEVEL(LEVEL), .TRG_ONE(TRG_ONE), .REL_ONE(REL_ONE),
    .LONG_ONE(LONG_ONE), .REP_ONE(REP_ONE)
  );

  always #5 CLK = ~CLK;

  // Model state: raw samples per edge, synchronised values per edge, accept edge of press.
  bit       m_samp[$];
  bit       m_s[$];
  int       m_edge  = 0;
  bit       m_level = 1'b0;
  bit       m_armed = 1'b0;
  int       m_press = 0;
  bit [4:0] exp_vec = 5'b0;

  always @(posedge CLK or negedge R_N) begin : mdl
    int k, d;
    bit s, nl, flip, fire, trg, rel, lng, rep;
    if (!R_N) begin
      m_samp.delete();
      m_s.delete();
      m_edge  <= 0;
      m_level <= 1'b0;
      m_armed <= 1'b0;
      m_press <= 0;
      exp_vec <= 5'b0;
    end else begin
      k = m_edge + 1;
      s = (k > SYNC) ? m_samp[k-SYNC-1] : 1'b0;
      m_samp.push_back(PSW);
      m_s.push_back(s);
      nl = m_level;
      if (m_s.size() >= DB) begin
        flip = 1'b1;
        for (int j = 0; j < DB; j++)
          if (m_s[m_s.size()-1-j] == m_level) flip = 1'b0;
        if (flip) nl = !m_level;
      end
      fire = m_armed && EN;
      trg = 1'b0; rel = 1'b0; lng = 1'b0; rep = 1'b0;
      if (nl && !m_level) begin
        trg = fire;
        m_press <= k;
      end else if (!nl && m_level) begin
        rel = fire;
        m_armed <= 1'b1;
      end else if (nl) begin
        d = k - m_press;
        lng = fire && (d == LONG);
        rep = fire && (d > LONG) && (((d - LONG) % REP) == 0);
      end else if (k > SYNC && !s) begin
        m_armed <= 1'b1;
      end
      m_edge  <= k;
      m_level <= nl;
      exp_vec <= {nl, trg, rel, lng, rep};
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      n_chk++;
      if ({LEVEL, TRG_ONE, REL_ONE, LONG_ONE, REP_ONE} !== exp_vec) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t {LEVEL,TRG,REL,LONG,REP} dut=%b model=%b",
                 $time, {LEVEL, TRG_ONE, REL_ONE, LONG_ONE, REP_ONE}, exp_vec);
      end
    end
  end

  // Per-scenario event log, ticks counted in negedges since the last clear.
  int t;
  bit lvl_prev;
  int rise_t[$], fall_t[$], trg_t[$], rel_t[$], long_t[$], rep_t[$];

  task automatic clear_log();
    t = 0;
    lvl_prev = LEVEL;
    rise_t.delete(); fall_t.delete(); trg_t.delete();
    rel_t.delete(); long_t.delete(); rep_t.delete();
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      t++;
      if (LEVEL && !lvl_prev) rise_t.push_back(t);
      if (!LEVEL && lvl_prev) fall_t.push_back(t);
      lvl_prev = LEVEL;
      if (TRG_ONE)  trg_t.push_back(t);
      if (REL_ONE)  rel_t.push_back(t);
      if (LONG_ONE) long_t.push_back(t);
      if (REP_ONE)  rep_t.push_back(t);
    end
  endtask

  function automatic int first_of(input int q[$]);
    return (q.size() != 0) ? q[0] : -1;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CLK);
    R_N = 1'b0;
    repeat (cycles) @(negedge CLK);
    R_N = 1'b1;
  endtask

  initial begin
    #2 R_N = 1'b0;
    #1 chk_en = 1'b1;
    chk("reset_outputs", int'({LEVEL, TRG_ONE, REL_ONE, LONG_ONE, REP_ONE}), 0);
    repeat (3) @(negedge CLK);
    R_N = 1'b1;
    clear_log();
    step(5);

    // Clean press held 30 cycles, then release.
    clear_log();
    PSW = 1'b1;
    step(30);
    chk("s1_rise", first_of(rise_t), 6);
    chk("s1_trg", first_of(trg_t), 6);
    chk("s1_trg_cnt", trg_t.size(), 1);
    chk("s1_long", first_of(long_t), 16);
    chk("s1_rep_first", first_of(rep_t), 19);
    chk("s1_rep_cnt", rep_t.size(), 4);
    clear_log();
    PSW = 1'b0;
    step(10);
    chk("s1_rel", first_of(rel_t), 6);

    // Bounce rejection, then a stable press.
    clear_log();
    PSW = 1'b1; step(3);
    PSW = 1'b0; step(1);
    PSW = 1'b1; step(3);
    PSW = 1'b0; step(10);
    chk("s2_bounce_rise", rise_t.size(), 0);
    chk("s2_bounce_trg", trg_t.size(), 0);
    clear_log();
    PSW = 1'b1;
    step(10);
    chk("s2_trg", first_of(trg_t), 6);
    PSW = 1'b0;
    step(10);

    // Short press: no long or repeat.
    clear_log();
    PSW = 1'b1;
    step(8);
    chk("s3_trg", first_of(trg_t), 6);
    clear_log();
    PSW = 1'b0;
    step(10);
    chk("s3_rel", first_of(rel_t), 6);
    chk("s3_long_cnt", long_t.size(), 0);
    chk("s3_rep_cnt", rep_t.size(), 0);

    // Switch held through reset release.
    PSW = 1'b1;
    do_reset(3);
    clear_log();
    step(20);
    chk("s4_rise", first_of(rise_t), 6);
    chk("s4_pulses", trg_t.size() + long_t.size() + rep_t.size(), 0);
    clear_log();
    PSW = 1'b0;
    step(10);
    chk("s4_fall", first_of(fall_t), 6);
    chk("s4_rel_cnt", rel_t.size(), 0);
    clear_log();
    PSW = 1'b1;
    step(10);
    chk("s4_trg2", first_of(trg_t), 6);
    PSW = 1'b0;
    step(10);

    // EN low across the press edge, raised before long-press time.
    clear_log();
    EN = 1'b0;
    PSW = 1'b1;
    step(8);
    EN = 1'b1;
    step(20);
    chk("s5_trg_cnt", trg_t.size(), 0);
    chk("s5_long", first_of(long_t), 16);
    chk("s5_rep_first", first_of(rep_t), 19);
    clear_log();
    PSW = 1'b0;
    step(10);
    chk("s5_rel", first_of(rel_t), 6);

    // Async reset during LONG_HELD.
    clear_log();
    PSW = 1'b1;
    step(20);
    chk("s6_long_before", first_of(long_t), 16);
    @(posedge CLK);
    #2 R_N = 1'b0;
    #1 chk("s6_async_zero", int'({LEVEL, TRG_ONE, REL_ONE, LONG_ONE, REP_ONE}), 0);
    repeat (2) @(negedge CLK);
    R_N = 1'b1;
    clear_log();
    step(20);
    chk("s6_rise", first_of(rise_t), 6);
    chk("s6_pulses", trg_t.size() + long_t.size() + rep_t.size() + rel_t.size(), 0);
    clear_log();
    PSW = 1'b0;
    step(10);
    chk("s6_rel_cnt", rel_t.size(), 0);
    clear_log();
    PSW = 1'b1;
    step(10);
    chk("s6_trg2", first_of(trg_t), 6);
    PSW = 1'b0;
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
